// File: rtl/game_pkg.sv
// Shared game constants for the motion stage and the display stage:
// map geometry, finish line, FSM encoding and the jump sprite profile.
package game_pkg;

  localparam int TILE     = 80;
  localparam int LANES    = 5;
  localparam int WIN_Y    = 16080;
  localparam int BS_W     = 3;
  localparam int JUMP_LEN = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_SAMPLE,
    ST_FAIL,
    ST_WIN
  } state_t;

  typedef logic [BS_W-1:0] bs_t;

  // Height per profile step; the last entry lands the ball.
  localparam bs_t JUMP_PROFILE [JUMP_LEN] = '{
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  };

endpackage

// File: rtl/game_tick.sv
// Free-running game tick divider: one-cycle pulse every TICK_DIV clocks.
module game_tick #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic clrn,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball motion game logic: lateral and forward motion on the game tick, jump
// profile, and hole/finish detection against the map tile ROM.
module ball_motion
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 1000000,
  parameter int X_STEP     = 4,
  parameter int Y_SPEED    = 2,
  parameter int X_MAX      = 400,
  parameter int X_INIT     = 200,
  parameter int JUMP_TICKS = 4
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_jump,
  input  logic            tile_hole,
  output logic [2:0]      q_index_x,
  output logic [10:0]     q_index_y,
  output logic [9:0]      x_ball,
  output logic [25:0]     y_ball,
  output logic [BS_W-1:0] ball_state,
  output logic            fail,
  output logic            win
);

  localparam int JW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;

  state_t        state;
  logic          tick;
  logic [6:0]    y_frac;
  logic [10:0]   tile_y;
  logic          active;
  logic          pending;
  logic          jump_prev;
  logic [3:0]    phase;
  logic [JW-1:0] jcnt;
  logic          grounded;
  logic          jump_edge;
  logic          jump_start;
  logic [7:0]    frac_sum;
  logic [9:0]    lane;

  game_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .clrn (clrn),
    .tick (tick)
  );

  assign grounded   = !active && (ball_state == '0);
  assign jump_edge  = btn_jump && !jump_prev;
  assign jump_start = (state == ST_RUN) && tick && grounded && pending;
  assign frac_sum   = {1'b0, y_frac} + 8'(Y_SPEED);
  assign lane       = x_ball / 10'(TILE);
  assign q_index_x  = (lane > 10'(LANES - 1)) ? 3'(LANES - 1) : lane[2:0];
  assign q_index_y  = tile_y;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      x_ball     <= 10'(X_INIT);
      y_ball     <= '0;
      y_frac     <= '0;
      tile_y     <= '0;
      ball_state <= '0;
      active     <= 1'b0;
      phase      <= '0;
      jcnt       <= '0;
      pending    <= 1'b0;
      jump_prev  <= 1'b0;
      fail       <= 1'b0;
      win        <= 1'b0;
    end else begin
      jump_prev <= btn_jump;
      // A jump request is only latched while the ball can actually take off.
      if (jump_start) begin
        pending <= 1'b0;
      end else if ((state == ST_RUN) && grounded && jump_edge) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            if (btn_left && !btn_right) begin
              x_ball <= (x_ball < 10'(X_STEP)) ? '0 : x_ball - 10'(X_STEP);
            end else if (btn_right && !btn_left) begin
              x_ball <= (x_ball > 10'(X_MAX - X_STEP)) ? 10'(X_MAX) : x_ball + 10'(X_STEP);
            end
            y_ball <= y_ball + 26'(Y_SPEED);
            if (frac_sum >= 8'(TILE)) begin
              y_frac <= 7'(frac_sum - 8'(TILE));
              tile_y <= tile_y + 11'd1;
            end else begin
              y_frac <= frac_sum[6:0];
            end
            if (grounded) begin
              if (pending) begin
                active     <= 1'b1;
                phase      <= '0;
                jcnt       <= '0;
                ball_state <= JUMP_PROFILE[0];
              end
            end else if (jcnt == JW'(JUMP_TICKS - 1)) begin
              jcnt       <= '0;
              phase      <= phase + 4'd1;
              ball_state <= JUMP_PROFILE[phase + 4'd1];
              if (phase == 4'(JUMP_LEN - 2)) active <= 1'b0;
            end else begin
              jcnt <= jcnt + 1'b1;
            end
            state <= ST_WAIT;
          end
        end
        // The query indices already show the new position; this cycle covers the ROM latency.
        ST_WAIT: state <= ST_SAMPLE;
        ST_SAMPLE: begin
          if (tile_hole && grounded) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
          end else if (y_ball > 26'(WIN_Y)) begin
            state <= ST_WIN;
            win   <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_FAIL: state <= ST_FAIL;
        ST_WIN:  state <= ST_WIN;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
